// File: rtl/axi_txn_tracker.sv
// axi_txn_tracker
// Tracks outstanding AXI transactions for one direction (AW/B when IsRead=0,
// AR/R when IsRead=1). Each in-flight ID owns a linked list of slots kept in
// local registers. Every slot carries a prescaled timeout counter. A small
// RUN/ERROR FSM flushes all state on a timeout or on an unexpected response,
// and holds that state until software acknowledges it with clear_i.
//
// Ports:
//   clk_i, rst_ni          clock, synchronous active-low reset
//   req_valid_i/ready_o    address handshake tap / tracker can accept
//   req_id_i, req_len_i    address ID and len (beats-1)
//   rsp_valid_i, rsp_id_i  response handshake tap and ID
//   rsp_last_i             R last (read mode only)
//   budget_base_i          base timeout budget in ticks
//   clear_i                software acknowledge, leaves ERROR
//   outstanding_o          occupied slot count
//   latency_valid_o/_o     completion pulse and elapsed ticks
//   timeout_o, unexp_rsp_o sticky error flags
//   err_id_o               ID of the first error
//   reset_req_o            high while in ERROR
//
// Optional build macro TXN_TRACKER_PERF_EN adds lat_max_o (running max
// latency) and done_cnt_o (completion count).
//
// state | meaning
// RUN   | tracking transactions normally
// ERROR | state flushed, waiting for clear_i

module axi_txn_tracker #(
    parameter int NumTxns      = 8,
    parameter int NumIds       = 4,
    parameter int IdWidth      = 4,
    parameter int LenWidth     = 8,
    parameter int CntWidth     = 12,
    parameter int PrescalerDiv = 4,
    parameter int IsRead       = 0
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           req_valid_i,
    output logic                           req_ready_o,
    input  logic [IdWidth-1:0]             req_id_i,
    input  logic [LenWidth-1:0]            req_len_i,
    input  logic                           rsp_valid_i,
    input  logic [IdWidth-1:0]             rsp_id_i,
    input  logic                           rsp_last_i,
    input  logic [CntWidth-1:0]            budget_base_i,
    input  logic                           clear_i,
    output logic [$clog2(NumTxns+1)-1:0]   outstanding_o,
    output logic                           latency_valid_o,
    output logic [CntWidth-1:0]            latency_o,
    output logic                           timeout_o,
    output logic                           unexp_rsp_o,
    output logic [IdWidth-1:0]             err_id_o,
    output logic                           reset_req_o
`ifdef TXN_TRACKER_PERF_EN
    ,
    output logic [CntWidth-1:0]            lat_max_o,
    output logic [31:0]                    done_cnt_o
`endif
);

    localparam int  SlotW    = $clog2(NumTxns);
    localparam int  IdeW     = (NumIds > 1) ? $clog2(NumIds) : 1;
    localparam int  PresW    = (PrescalerDiv > 1) ? $clog2(PrescalerDiv) : 1;
    localparam int  LenShift = $clog2(PrescalerDiv);
    localparam int  OutW     = $clog2(NumTxns + 1);
    localparam int  SumW     = CntWidth + 1;
    localparam bit  ReadMode = (IsRead != 0);

    typedef enum logic {ST_RUN, ST_ERROR} state_e;

    state_e                 r_state;
    logic [PresW-1:0]       r_presc;

    logic [NumTxns-1:0]     r_slot_vld;
    logic [IdWidth-1:0]     r_slot_id     [NumTxns];
    logic [CntWidth-1:0]    r_slot_budget [NumTxns];
    logic [CntWidth-1:0]    r_slot_cnt    [NumTxns];
    logic [LenWidth-1:0]    r_slot_beats  [NumTxns];
    logic [SlotW-1:0]       r_slot_next   [NumTxns];

    logic [NumIds-1:0]      r_ide_vld;
    logic [IdWidth-1:0]     r_ide_id   [NumIds];
    logic [SlotW-1:0]       r_ide_head [NumIds];
    logic [SlotW-1:0]       r_ide_tail [NumIds];

    logic                   w_tick;
    logic                   w_run;
    logic [LenWidth-1:0]    w_len_scaled;
    logic [SumW-1:0]        w_budget_sum;
    logic [CntWidth-1:0]    w_budget;

    logic                   w_free_slot_ok;
    logic [SlotW-1:0]       w_free_slot;
    logic                   w_free_ide_ok;
    logic [IdeW-1:0]        w_free_ide;
    logic                   w_req_hit;
    logic [IdeW-1:0]        w_req_ide;
    logic                   w_rsp_hit;
    logic [IdeW-1:0]        w_rsp_ide;
    logic                   w_to_found;
    logic [IdWidth-1:0]     w_to_id;
    logic [OutW-1:0]        w_outstanding;

    logic [SlotW-1:0]       w_tgt_slot;
    logic [LenWidth-1:0]    w_tgt_beats;
    logic [CntWidth-1:0]    w_tgt_cnt;
    logic [CntWidth-1:0]    w_tgt_cnt_nxt;
    logic [CntWidth-1:0]    w_lat;

    logic                   w_enq;
    logic                   w_rsp_act;
    logic                   w_bad_last;
    logic                   w_complete;
    logic                   w_beat;
    logic                   w_unexp;
    logic                   w_err;
    logic                   w_ide_release;

    assign w_run  = (r_state == ST_RUN);
    assign w_tick = (r_presc == PresW'(PrescalerDiv - 1));

    // Budget is widened by one bit so an overflow can saturate instead of wrap.
    assign w_len_scaled = req_len_i >> LenShift;
    assign w_budget_sum = SumW'(budget_base_i) + SumW'(w_len_scaled) + SumW'(2);
    assign w_budget     = w_budget_sum[CntWidth] ? '1 : w_budget_sum[CntWidth-1:0];

    always_comb begin
        w_free_slot_ok = 1'b0;
        w_free_slot    = '0;
        w_to_found     = 1'b0;
        w_to_id        = '0;
        w_outstanding  = '0;
        for (int i = NumTxns - 1; i >= 0; i--) begin
            if (!r_slot_vld[i]) begin
                w_free_slot_ok = 1'b1;
                w_free_slot    = SlotW'(i);
            end
            if (r_slot_vld[i] && (r_slot_cnt[i] == '0)) begin
                w_to_found = 1'b1;
                w_to_id    = r_slot_id[i];
            end
            w_outstanding = w_outstanding + OutW'(r_slot_vld[i]);
        end
    end

    always_comb begin
        w_free_ide_ok = 1'b0;
        w_free_ide    = '0;
        w_req_hit     = 1'b0;
        w_req_ide     = '0;
        w_rsp_hit     = 1'b0;
        w_rsp_ide     = '0;
        for (int i = NumIds - 1; i >= 0; i--) begin
            if (!r_ide_vld[i]) begin
                w_free_ide_ok = 1'b1;
                w_free_ide    = IdeW'(i);
            end
            if (r_ide_vld[i] && (r_ide_id[i] == req_id_i)) begin
                w_req_hit = 1'b1;
                w_req_ide = IdeW'(i);
            end
            if (r_ide_vld[i] && (r_ide_id[i] == rsp_id_i)) begin
                w_rsp_hit = 1'b1;
                w_rsp_ide = IdeW'(i);
            end
        end
    end

    assign w_tgt_slot    = r_ide_head[w_rsp_ide];
    assign w_tgt_beats   = r_slot_beats[w_tgt_slot];
    assign w_tgt_cnt     = r_slot_cnt[w_tgt_slot];
    // Latency includes the tick landing on the completing edge.
    assign w_tgt_cnt_nxt = (w_tick && (w_tgt_cnt != '0)) ? w_tgt_cnt - CntWidth'(1) : w_tgt_cnt;
    assign w_lat         = r_slot_budget[w_tgt_slot] - w_tgt_cnt_nxt;

    assign req_ready_o = w_run && w_free_slot_ok && (w_req_hit || w_free_ide_ok);
    assign w_enq       = req_valid_i && req_ready_o;
    assign w_rsp_act   = w_run && rsp_valid_i;

    // In read mode last must land exactly on the final beat; an extra beat
    // after the count is exhausted is just as wrong as an early last.
    assign w_bad_last    = ReadMode && (rsp_last_i ? (w_tgt_beats != '0) : (w_tgt_beats == '0));
    assign w_complete    = w_rsp_act && w_rsp_hit && (!ReadMode || (rsp_last_i && (w_tgt_beats == '0)));
    assign w_beat        = ReadMode && w_rsp_act && w_rsp_hit && !rsp_last_i && (w_tgt_beats != '0);
    assign w_unexp       = w_rsp_act && (!w_rsp_hit || w_bad_last);
    assign w_err         = w_run && (w_to_found || w_unexp);
    assign w_ide_release = w_complete && (r_ide_head[w_rsp_ide] == r_ide_tail[w_rsp_ide]);

    assign outstanding_o = w_outstanding;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state         <= ST_RUN;
            r_presc         <= '0;
            r_slot_vld      <= '0;
            r_ide_vld       <= '0;
            latency_valid_o <= 1'b0;
            latency_o       <= '0;
            timeout_o       <= 1'b0;
            unexp_rsp_o     <= 1'b0;
            err_id_o        <= '0;
            reset_req_o     <= 1'b0;
            for (int i = 0; i < NumTxns; i++) begin
                r_slot_id[i]     <= '0;
                r_slot_budget[i] <= '0;
                r_slot_cnt[i]    <= '0;
                r_slot_beats[i]  <= '0;
                r_slot_next[i]   <= '0;
            end
            for (int i = 0; i < NumIds; i++) begin
                r_ide_id[i]   <= '0;
                r_ide_head[i] <= '0;
                r_ide_tail[i] <= '0;
            end
`ifdef TXN_TRACKER_PERF_EN
            lat_max_o  <= '0;
            done_cnt_o <= '0;
`endif
        end else begin
            latency_valid_o <= 1'b0;
            r_presc         <= w_tick ? '0 : r_presc + PresW'(1);
            case (r_state)
                ST_RUN: begin
                    if (w_err) begin
                        r_state     <= ST_ERROR;
                        r_slot_vld  <= '0;
                        r_ide_vld   <= '0;
                        reset_req_o <= 1'b1;
                        if (w_unexp) unexp_rsp_o <= 1'b1;
                        if (w_to_found) begin
                            timeout_o <= 1'b1;
                            err_id_o  <= w_to_id;
                        end else begin
                            err_id_o  <= rsp_id_i;
                        end
                    end else begin
                        for (int i = 0; i < NumTxns; i++) begin
                            if (r_slot_vld[i] && w_tick && (r_slot_cnt[i] != '0))
                                r_slot_cnt[i] <= r_slot_cnt[i] - CntWidth'(1);
                        end
                        if (w_beat)
                            r_slot_beats[w_tgt_slot] <= w_tgt_beats - LenWidth'(1);
                        if (w_complete) begin
                            r_slot_vld[w_tgt_slot] <= 1'b0;
                            latency_valid_o        <= 1'b1;
                            latency_o              <= w_lat;
`ifdef TXN_TRACKER_PERF_EN
                            if (w_lat > lat_max_o) lat_max_o <= w_lat;
                            done_cnt_o <= done_cnt_o + 32'd1;
`endif
                            if (w_ide_release)
                                r_ide_vld[w_rsp_ide] <= 1'b0;
                            else
                                r_ide_head[w_rsp_ide] <= r_slot_next[w_tgt_slot];
                        end
                        if (w_enq) begin
                            r_slot_vld[w_free_slot]    <= 1'b1;
                            r_slot_id[w_free_slot]     <= req_id_i;
                            r_slot_budget[w_free_slot] <= w_budget;
                            r_slot_cnt[w_free_slot]    <= w_budget;
                            r_slot_beats[w_free_slot]  <= req_len_i;
                            if (w_req_hit) begin
                                if (w_ide_release && (w_rsp_ide == w_req_ide)) begin
                                    // The ID's only slot retires this cycle; the
                                    // entry survives and restarts on the new slot.
                                    r_ide_vld[w_req_ide]  <= 1'b1;
                                    r_ide_head[w_req_ide] <= w_free_slot;
                                end else begin
                                    r_slot_next[r_ide_tail[w_req_ide]] <= w_free_slot;
                                end
                                r_ide_tail[w_req_ide] <= w_free_slot;
                            end else begin
                                r_ide_vld[w_free_ide]  <= 1'b1;
                                r_ide_id[w_free_ide]   <= req_id_i;
                                r_ide_head[w_free_ide] <= w_free_slot;
                                r_ide_tail[w_free_ide] <= w_free_slot;
                            end
                        end
                    end
                end
                ST_ERROR: begin
                    if (clear_i) begin
                        r_state     <= ST_RUN;
                        r_presc     <= '0;
                        timeout_o   <= 1'b0;
                        unexp_rsp_o <= 1'b0;
                        err_id_o    <= '0;
                        reset_req_o <= 1'b0;
`ifdef TXN_TRACKER_PERF_EN
                        lat_max_o   <= '0;
                        done_cnt_o  <= '0;
`endif
                    end
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_txn_tracker.sv
// Bench for axi_txn_tracker. Three instances are used:
//   0: write mode, tick every cycle
//   1: read mode, tick every cycle
//   2: write mode, tick every 4 cycles
// Expected latencies go into a scoreboard queue when the response is driven.
// A monitor pops and compares them whenever a latency pulse appears.

module tb_axi_txn_tracker;
    localparam int NDut = 3;

    logic        clk_sys = 1'b0;
    logic        rst_n;
    logic        req_valid   [NDut];
    logic        req_ready   [NDut];
    logic [3:0]  req_id      [NDut];
    logic [7:0]  req_len     [NDut];
    logic        rsp_valid   [NDut];
    logic [3:0]  rsp_id      [NDut];
    logic        rsp_last    [NDut];
    logic [11:0] budget      [NDut];
    logic        clear       [NDut];
    logic [3:0]  outstanding [NDut];
    logic        lat_vld     [NDut];
    logic [11:0] lat         [NDut];
    logic        timeout     [NDut];
    logic        unexp       [NDut];
    logic [3:0]  err_id      [NDut];
    logic        reset_req   [NDut];
`ifdef TXN_TRACKER_PERF_EN
    logic [11:0] lat_max     [NDut];
    logic [31:0] done_cnt    [NDut];
`endif

    typedef struct {int dut; int id; int cyc;} pend_t;
    typedef struct {int dut; int lat;} exp_t;
    pend_t pend_q[$];
    exp_t  exp_q[$];

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always #5 clk_sys = ~clk_sys;
    always @(posedge clk_sys) cyc <= cyc + 1;

    for (genvar g = 0; g < NDut; g++) begin : g_dut
        axi_txn_tracker #(
            .PrescalerDiv ((g == 2) ? 4 : 1),
            .IsRead       ((g == 1) ? 1 : 0)
        ) u_dut (
            .clk_i           (clk_sys),
            .rst_ni          (rst_n),
            .req_valid_i     (req_valid[g]),
            .req_ready_o     (req_ready[g]),
            .req_id_i        (req_id[g]),
            .req_len_i       (req_len[g]),
            .rsp_valid_i     (rsp_valid[g]),
            .rsp_id_i        (rsp_id[g]),
            .rsp_last_i      (rsp_last[g]),
            .budget_base_i   (budget[g]),
            .clear_i         (clear[g]),
            .outstanding_o   (outstanding[g]),
            .latency_valid_o (lat_vld[g]),
            .latency_o       (lat[g]),
            .timeout_o       (timeout[g]),
            .unexp_rsp_o     (unexp[g]),
            .err_id_o        (err_id[g]),
            .reset_req_o     (reset_req[g])
`ifdef TXN_TRACKER_PERF_EN
            ,
            .lat_max_o       (lat_max[g]),
            .done_cnt_o      (done_cnt[g])
`endif
        );
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    // Expected latency (tick-every-cycle instances) = edge of response minus
    // edge of the matching request; oldest request of that ID completes first.
    task automatic push_exp(input int d, input int id, input int stamp);
        int idx;
        idx = -1;
        for (int k = 0; k < pend_q.size(); k++)
            if (idx < 0 && pend_q[k].dut == d && pend_q[k].id == id) idx = k;
        if (idx >= 0) begin
            exp_q.push_back('{d, stamp - pend_q[idx].cyc});
            pend_q.delete(idx);
        end
    endtask

    task automatic drop_pend(input int d);
        for (int k = pend_q.size() - 1; k >= 0; k--)
            if (pend_q[k].dut == d) pend_q.delete(k);
    endtask

    task automatic drive(input int d, input bit rv, input int rid, input int rlen,
                         input bit sv, input int sid, input bit slast, input bit sdone);
        int stamp;
        stamp        = cyc + 1;
        req_valid[d] = rv;
        req_id[d]    = rid[3:0];
        req_len[d]   = rlen[7:0];
        rsp_valid[d] = sv;
        rsp_id[d]    = sid[3:0];
        rsp_last[d]  = slast;
        if (sdone) push_exp(d, sid, stamp);
        if (rv) pend_q.push_back('{d, rid, stamp});
        step(1);
        req_valid[d] = 1'b0;
        rsp_valid[d] = 1'b0;
        rsp_last[d]  = 1'b0;
    endtask

    task automatic req(input int d, input int id, input int len);
        drive(d, 1'b1, id, len, 1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic rsp(input int d, input int id, input bit last, input bit done);
        drive(d, 1'b0, 0, 0, 1'b1, id, last, done);
    endtask

    task automatic pulse_clear(input int d);
        clear[d] = 1'b1;
        step(1);
        clear[d] = 1'b0;
    endtask

    task automatic peek_ready(input int d, input int id, output logic rdy);
        req_id[d] = id[3:0];
        #1;
        rdy = req_ready[d];
    endtask

    always @(negedge clk_sys) begin
        for (int d = 0; d < NDut; d++) begin
            if (lat_vld[d] === 1'b1) begin
                int idx;
                idx = -1;
                for (int k = 0; k < exp_q.size(); k++)
                    if (idx < 0 && exp_q[k].dut == d) idx = k;
                if (idx < 0) begin
                    check_val("lat_spurious", 32'd1, 32'd0);
                end else begin
                    check_val("latency", 32'(lat[d]), 32'(exp_q[idx].lat));
                    exp_q.delete(idx);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic rdy;
        int   n;
        rst_n = 1'b0;
        for (int d = 0; d < NDut; d++) begin
            req_valid[d] = 1'b0; req_id[d] = '0; req_len[d] = '0;
            rsp_valid[d] = 1'b0; rsp_id[d] = '0; rsp_last[d] = 1'b0;
            budget[d] = 12'd40; clear[d] = 1'b0;
        end
        step(3);
        rst_n = 1'b1;
        step(1);

        // reset state
        check_val("rst_ready",     32'(req_ready[0]),   32'd1);
        check_val("rst_outst",     32'(outstanding[0]), 32'd0);
        check_val("rst_timeout",   32'(timeout[0]),     32'd0);
        check_val("rst_unexp",     32'(unexp[0]),       32'd0);
        check_val("rst_err_id",    32'(err_id[0]),      32'd0);
        check_val("rst_reset_req", 32'(reset_req[0]),   32'd0);
        check_val("rst_lat_vld",   32'(lat_vld[0]),     32'd0);

        // single write, B five cycles later -> latency 5
        budget[0] = 12'd10;
        req(0, 3, 0);
        check_val("t1_outst1", 32'(outstanding[0]), 32'd1);
        step(4);
        rsp(0, 3, 1'b0, 1'b1);
        check_val("t1_outst0", 32'(outstanding[0]), 32'd0);
        check_val("t1_unexp",  32'(unexp[0]),       32'd0);
        budget[0] = 12'd40;

        // same ID re-enqueued while its only slot retires
        req(0, 5, 0);
        drive(0, 1'b1, 5, 0, 1'b1, 5, 1'b0, 1'b1);
        check_val("reenq_outst", 32'(outstanding[0]), 32'd1);
        rsp(0, 5, 1'b0, 1'b1);
        check_val("reenq_drain", 32'(outstanding[0]), 32'd0);
        check_val("reenq_unexp", 32'(unexp[0]),       32'd0);

        // three id=1, clear_i in RUN is a no-op, id=2 enqueued with last B
        for (int k = 0; k < 3; k++) req(0, 1, 0);
        pulse_clear(0);
        check_val("run_clear_outst", 32'(outstanding[0]), 32'd3);
        rsp(0, 1, 1'b0, 1'b1);
        rsp(0, 1, 1'b0, 1'b1);
        drive(0, 1'b1, 2, 0, 1'b1, 1, 1'b0, 1'b1);
        check_val("t2_outst", 32'(outstanding[0]), 32'd1);
        check_val("t2_unexp", 32'(unexp[0]),       32'd0);
        check_val("t2_to",    32'(timeout[0]),     32'd0);
        rsp(0, 2, 1'b0, 1'b1);

        // ID-entry and slot exhaustion
        req(0, 1, 0); req(0, 2, 0); req(0, 3, 0);
        for (int k = 0; k < 4; k++) req(0, 0, 0);
        peek_ready(0, 4, rdy);
        check_val("ids_full_new", 32'(rdy), 32'd0);
        peek_ready(0, 0, rdy);
        check_val("ids_full_old", 32'(rdy), 32'd1);
        req(0, 0, 0);
        check_val("slots_full_outst", 32'(outstanding[0]), 32'd8);
        peek_ready(0, 0, rdy);
        check_val("slots_full_rdy", 32'(rdy), 32'd0);
        rsp(0, 1, 1'b0, 1'b1);
        peek_ready(0, 4, rdy);
        check_val("id_freed_rdy", 32'(rdy), 32'd1);
        req(0, 4, 0);
        for (int k = 0; k < 5; k++) rsp(0, 0, 1'b0, 1'b1);
        rsp(0, 2, 1'b0, 1'b1);
        rsp(0, 3, 1'b0, 1'b1);
        rsp(0, 4, 1'b0, 1'b1);
        check_val("fill_drain", 32'(outstanding[0]), 32'd0);

        // timeout: budget 3+0+2 = 5 ticks, detected on the following edge
        budget[0] = 12'd3;
        req(0, 6, 0);
        step(5);
        check_val("to_early", 32'(timeout[0]), 32'd0);
        step(1);
        drop_pend(0);
        check_val("to_flag",      32'(timeout[0]),     32'd1);
        check_val("to_err_id",    32'(err_id[0]),      32'd6);
        check_val("to_reset_req", 32'(reset_req[0]),   32'd1);
        check_val("to_outst",     32'(outstanding[0]), 32'd0);
        check_val("to_unexp",     32'(unexp[0]),       32'd0);
        peek_ready(0, 6, rdy);
        check_val("to_ready", 32'(rdy), 32'd0);
        rsp(0, 6, 1'b0, 1'b0);
        check_val("err_rsp_ignored", 32'(unexp[0]), 32'd0);
        pulse_clear(0);
        check_val("clr_timeout",   32'(timeout[0]),   32'd0);
        check_val("clr_reset_req", 32'(reset_req[0]), 32'd0);
        check_val("clr_err_id",    32'(err_id[0]),    32'd0);
        check_val("clr_ready",     32'(req_ready[0]), 32'd1);
        budget[0] = 12'd40;

        // response with nothing outstanding
        rsp(0, 7, 1'b0, 1'b0);
        check_val("unexp_flag",  32'(unexp[0]),     32'd1);
        check_val("unexp_errid", 32'(err_id[0]),    32'd7);
        check_val("unexp_to",    32'(timeout[0]),   32'd0);
        check_val("unexp_rreq",  32'(reset_req[0]), 32'd1);
        pulse_clear(0);
        check_val("unexp_clr", 32'(unexp[0]), 32'd0);

        // read mode: early last is unexpected
        req(1, 2, 3);
        rsp(1, 2, 1'b0, 1'b0);
        rsp(1, 2, 1'b1, 1'b0);
        drop_pend(1);
        check_val("rd_bad_unexp", 32'(unexp[1]),       32'd1);
        check_val("rd_bad_errid", 32'(err_id[1]),      32'd2);
        check_val("rd_bad_outst", 32'(outstanding[1]), 32'd0);
        pulse_clear(1);
        check_val("rd_clr", 32'(unexp[1]), 32'd0);

        // read mode: last on the fourth beat completes
        req(1, 2, 3);
        for (int k = 0; k < 3; k++) rsp(1, 2, 1'b0, 1'b0);
        check_val("rd_mid_outst", 32'(outstanding[1]), 32'd1);
        rsp(1, 2, 1'b1, 1'b1);
        check_val("rd_ok_outst", 32'(outstanding[1]), 32'd0);
        check_val("rd_ok_unexp", 32'(unexp[1]),       32'd0);

        // prescaled timebase: budget 3+(8>>2)+2 = 7 ticks of 4 cycles; the
        // first tick lands 1..4 edges after enqueue, detection one edge later
        budget[2] = 12'd3;
        req(2, 5, 8);
        drop_pend(2);
        n = 0;
        while (n < 60 && timeout[2] !== 1'b1) begin
            step(1);
            n++;
        end
        check_val("pd_to_seen",   32'(timeout[2]),              32'd1);
        check_val("pd_to_window", 32'(n >= 26 && n <= 29),      32'd1);
        check_val("pd_err_id",    32'(err_id[2]),               32'd5);

        // reset mid-operation discards everything
        req(0, 9, 0);
        check_val("mid_rst_pre", 32'(outstanding[0]), 32'd1);
        rst_n = 1'b0;
        step(2);
        drop_pend(0);
        check_val("mid_rst_outst", 32'(outstanding[0]), 32'd0);
        check_val("mid_rst_pulse", 32'(lat_vld[0]),     32'd0);
        rst_n = 1'b1;
        step(1);
        check_val("mid_rst_ready", 32'(req_ready[0]), 32'd1);
        check_val("mid_rst_err2",  32'(reset_req[2]), 32'd0);

        step(3);
        check_val("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
